avalon_pio_bank: RTL and testbench

AVALON_PIO_BANK -- requirements
Module: avalon_pio_bank

---
 rtl/pio_bank_pkg.sv | 15 +
 rtl/pio_bank_chan.sv | 62 ++++++
 rtl/avalon_pio_bank.sv | 91 +++++++++
 tb/tb_avalon_pio_bank.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_bank_pkg.sv
// Shared register map for the Avalon PIO bank.
// Offsets are relative to the channel count.
package pio_bank_pkg;

  localparam int CTRL_AUTO_EN_BIT = 0;

  function automatic int status_ofs(input int num_ch);
    return num_ch;
  endfunction

  function automatic int ctrl_ofs(input int num_ch);
    return num_ch + 1;
  endfunction

endpackage

// File: rtl/pio_bank_chan.sv
// One PIO channel: byte-merged shadow, live copy
// and the pending flag that links them.
module pio_bank_chan
  import pio_bank_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                commit_i,
  output logic [DATA_W-1:0]   shadow_o,
  output logic [DATA_W-1:0]   live_o,
  output logic                pending_o
);

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] live_q, live_d;
  logic              pending_q, pending_d;

  // Commit sees the pre-write shadow; a same-cycle
  // write then re-arms pending for the next commit.
  always_comb begin
    shadow_d  = shadow_q;
    live_d    = live_q;
    pending_d = pending_q;
    if (commit_i && pending_q) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (wr_i) begin
      if (be_i == '0) begin
        pending_d = 1'b0;
      end else begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (be_i[b]) shadow_d[b*8 +: 8] = wdata_i[b*8 +: 8];
        end
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q  <= RESET_VAL;
      live_q    <= RESET_VAL;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      live_q    <= live_d;
      pending_q <= pending_d;
    end
  end

  assign shadow_o  = shadow_q;
  assign live_o    = live_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/avalon_pio_bank.sv
// Avalon-MM bank of double-buffered output channels,
// committed together on a frame edge or on demand.
module avalon_pio_bank
  import pio_bank_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                NUM_CH    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               ADDR_W    = $clog2(NUM_CH+2)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic                     read_n,
  input  logic [DATA_W/8-1:0]      byteenable,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  input  logic                     frame_sync,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     update
);

  localparam logic [ADDR_W-1:0] STATUS_A =
    ADDR_W'(status_ofs(NUM_CH));
  localparam logic [ADDR_W-1:0] CTRL_A =
    ADDR_W'(ctrl_ofs(NUM_CH));
  localparam int PW = (NUM_CH < DATA_W) ? NUM_CH : DATA_W;

  logic              wr, rd;
  logic              status_wr, ctrl_wr;
  logic              fs_q, fs_rise, commit;
  logic              auto_en_q;
  logic              update_q;
  logic [DATA_W-1:0] readdata_q, rdata_d;
  logic [NUM_CH-1:0] pending;
  logic [DATA_W-1:0] shadow [NUM_CH];

  assign wr        = chipselect & ~write_n;
  assign rd        = chipselect & ~read_n;
  assign status_wr = wr && (address == STATUS_A);
  assign ctrl_wr   = wr && (address == CTRL_A);
  assign fs_rise   = frame_sync & ~fs_q;
  assign commit    = (fs_rise & auto_en_q) | status_wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pio_bank_chan #(
      .DATA_W   (DATA_W),
      .RESET_VAL(RESET_VAL)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_i     (wr && (address == ADDR_W'(i))),
      .be_i     (byteenable),
      .wdata_i  (writedata),
      .commit_i (commit),
      .shadow_o (shadow[i]),
      .live_o   (out_port[i*DATA_W +: DATA_W]),
      .pending_o(pending[i])
    );
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (address == ADDR_W'(i)) rdata_d = shadow[i];
    end
    if (address == STATUS_A) rdata_d[PW-1:0] = pending[PW-1:0];
    if (address == CTRL_A) rdata_d[CTRL_AUTO_EN_BIT] = auto_en_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fs_q       <= 1'b0;
      auto_en_q  <= 1'b1;
      update_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      fs_q     <= frame_sync;
      update_q <= commit & (|pending);
      if (rd) readdata_q <= rdata_d;
      if (ctrl_wr && byteenable[0])
        auto_en_q <= writedata[CTRL_AUTO_EN_BIT];
    end
  end

  assign readdata = readdata_q;
  assign update   = update_q;

endmodule

// File: tb/tb_avalon_pio_bank.sv
// Scoreboard bench for avalon_pio_bank: stimulus queues
// expected reads/updates, a monitor checks them.
module tb_avalon_pio_bank;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int AW = $clog2(NC+2);
  localparam int OW = NC*DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic          read_n = 1'b1;
  logic [3:0]    byteenable = '0;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic          frame_sync = 1'b0;
  logic [OW-1:0] out_port;
  logic          update;

  avalon_pio_bank #(
    .DATA_W(DW), .NUM_CH(NC), .RESET_VAL('0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .read_n(read_n), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata),
    .frame_sync(frame_sync), .out_port(out_port),
    .update(update)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [OW-1:0] exp;
  } chk_t;

  chk_t rd_q[$];
  chk_t out_q[$];
  chk_t upd_q[$];

  int   n_chk = 0;
  int   n_fail = 0;
  logic rd_vld = 1'b0;
  logic out_chk = 1'b0;
  logic [DW-1:0] live_m [NC];

  always @(posedge clk) rd_vld <= chipselect & ~read_n;

  task automatic cmp(input string nm,
                     input logic [OW-1:0] act,
                     input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares whenever the DUT presents a result
  always @(negedge clk) begin
    chk_t c;
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_read: got %h expected none",
                 readdata);
      end else begin
        c = rd_q.pop_front();
        cmp(c.name, OW'(readdata), c.exp);
      end
    end
    if (out_chk && out_q.size() != 0) begin
      c = out_q.pop_front();
      cmp(c.name, out_port, c.exp);
    end
    if (update === 1'b1) begin
      if (upd_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_update: got 1 expected 0");
      end else begin
        c = upd_q.pop_front();
        cmp(c.name, out_port, c.exp);
      end
    end
  end

  function automatic logic [OW-1:0] pack_live();
    logic [OW-1:0] v;
    for (int i = 0; i < NC; i++) v[i*DW +: DW] = live_m[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_clear();
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    byteenable = '0;
  endtask

  task automatic drive_wr(input int a, input logic [3:0] be,
                          input logic [DW-1:0] d);
    address = AW'(a); byteenable = be; writedata = d;
    chipselect = 1'b1; write_n = 1'b0;
  endtask

  task automatic wr(input int a, input logic [3:0] be,
                    input logic [DW-1:0] d);
    drive_wr(a, be, d);
    step();
    bus_clear();
  endtask

  task automatic rd(input string nm, input int a,
                    input logic [DW-1:0] exp);
    rd_q.push_back('{nm, OW'(exp)});
    address = AW'(a); chipselect = 1'b1; read_n = 1'b0;
    step();
    bus_clear();
    step();
  endtask

  task automatic chk_out(input string nm);
    out_q.push_back('{nm, pack_live()});
    out_chk = 1'b1;
    step();
    out_chk = 1'b0;
  endtask

  task automatic expect_upd(input string nm);
    upd_q.push_back('{nm, pack_live()});
  endtask

  task automatic fs_pulse();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NC; i++) live_m[i] = '0;
    #23 reset_n = 1'b1;
    step();

    chk_out("reset_out_port");
    rd("reset_status", NC, 32'h0);
    rd("reset_ctrl", NC+1, 32'h1);

    wr(1, 4'hF, 32'hDEADBEEF);
    rd("status_after_wr1", NC, 32'h2);
    chk_out("ch1_not_live_yet");
    live_m[1] = 32'hDEADBEEF;
    expect_upd("fs_commit_ch1");
    fs_pulse();
    idle(2);
    rd("status_after_fs", NC, 32'h0);
    chk_out("ch1_live");

    wr(0, 4'hF, 32'h11223344);
    live_m[0] = 32'h11223344;
    expect_upd("commit_ch0_full");
    wr(NC, 4'hF, 32'h0);
    idle(2);
    wr(0, 4'h5, 32'hAABBCCDD);
    rd("ch0_shadow_merged", 0, 32'h11BB33DD);
    live_m[0] = 32'h11BB33DD;
    expect_upd("commit_ch0_merged");
    wr(NC, 4'hF, 32'h0);
    idle(2);
    chk_out("ch0_merge_live");

    wr(2, 4'hF, 32'h4);
    live_m[2] = 32'h4;
    expect_upd("fs_same_cycle_wr");
    drive_wr(2, 4'hF, 32'h5);
    frame_sync = 1'b1;
    step();
    bus_clear();
    frame_sync = 1'b0;
    idle(2);
    chk_out("ch2_live_prewrite");
    rd("ch2_shadow_new", 2, 32'h5);
    rd("status_ch2_still", NC, 32'h4);
    live_m[2] = 32'h5;
    expect_upd("commit_ch2_new");
    wr(NC, 4'hF, 32'h0);
    idle(2);

    wr(NC+1, 4'hF, 32'h0);
    rd("ctrl_auto_off", NC+1, 32'h0);
    wr(3, 4'hF, 32'h7);
    fs_pulse();
    fs_pulse();
    fs_pulse();
    idle(2);
    chk_out("ch3_held_no_auto");
    rd("status_ch3_pend", NC, 32'h8);
    live_m[3] = 32'h7;
    expect_upd("manual_commit_ch3");
    wr(NC, 4'hF, 32'h0);
    idle(2);
    chk_out("ch3_live");

    wr(NC+1, 4'hF, 32'h1);
    wr(1, 4'hF, 32'h12345678);
    live_m[1] = 32'h12345678;
    expect_upd("fs_and_commit_once");
    drive_wr(NC, 4'hF, 32'h0);
    frame_sync = 1'b1;
    step();
    bus_clear();
    frame_sync = 1'b0;
    idle(4);
    rd("unmapped_addr6", NC+2, 32'h0);
    rd("unmapped_addr7", NC+3, 32'h0);

    wr(0, 4'hF, 32'h99);
    wr(0, 4'h0, 32'hFFFFFFFF);
    rd("status_be0_cleared", NC, 32'h0);
    wr(NC, 4'hF, 32'h0);
    idle(2);
    rd("ch0_be0_nochange", 0, 32'h99);
    chk_out("live_after_noop_commit");

    wr(1, 4'hF, 32'hCAFE);
    #2 reset_n = 1'b0;
    for (int i = 0; i < NC; i++) live_m[i] = '0;
    frame_sync = 1'b1;
    step();
    reset_n = 1'b1;
    idle(3);
    frame_sync = 1'b0;
    idle(2);
    chk_out("reset_mid_frame_out");
    rd("reset_mid_status", NC, 32'h0);
    rd("reset_mid_ch1", 1, 32'h0);
    rd("reset_mid_ctrl", NC+1, 32'h1);
    idle(4);

    cmp("rd_queue_drained", OW'(rd_q.size()), '0);
    cmp("upd_queue_drained", OW'(upd_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
